// File: rtl/pipelined_left_rotator.sv
// pipelined_left_rotator
// Elastic left rotator / logical left shifter. There is one register stage per
// amount bit. Stage k moves the word by 2^k when amount bit k is set. The
// amount and the mode travel with the data, so every stage decides locally.
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid && ready are both high. A producer must hold valid and its payload
// stable until that edge. The result side keeps out_valid/out_data stable
// while out_valid && !out_ready.
module pipelined_left_rotator #(
    parameter int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Stage registers S0..S(AMT_W-1); the last one is the output register
    logic             r_v [AMT_W];
    logic [WIDTH-1:0] r_d [AMT_W];
    logic [AMT_W-1:0] r_a [AMT_W];
    logic             r_m [AMT_W];

    // Per-stage load enables and the values each stage would load
    logic [AMT_W-1:0] w_en;
    logic             w_src_v [AMT_W];
    logic [WIDTH-1:0] w_src_d [AMT_W];
    logic [AMT_W-1:0] w_src_a [AMT_W];
    logic             w_src_m [AMT_W];
    logic [WIDTH-1:0] w_rot   [AMT_W];
    logic [WIDTH-1:0] w_shl   [AMT_W];
    logic [WIDTH-1:0] w_nxt_d [AMT_W];

    // Per-stage datapath: pick the source, then apply this stage's fixed 2^k move
    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        localparam int S = 1 << k;

        if (k == 0) begin : g_first
            assign w_src_v[k] = in_valid;
            assign w_src_d[k] = in_data;
            assign w_src_a[k] = in_amt;
            assign w_src_m[k] = in_mode;
        end else begin : g_next
            assign w_src_v[k] = r_v[k-1];
            assign w_src_d[k] = r_d[k-1];
            assign w_src_a[k] = r_a[k-1];
            assign w_src_m[k] = r_m[k-1];
        end

        // Rotate wraps the top S bits into the bottom; shift zero-fills them
        assign w_rot[k]   = {w_src_d[k][WIDTH-1-S:0], w_src_d[k][WIDTH-1:WIDTH-S]};
        assign w_shl[k]   = {w_src_d[k][WIDTH-1-S:0], {S{1'b0}}};
        assign w_nxt_d[k] = !w_src_a[k][k] ? w_src_d[k]
                          : (w_src_m[k] ? w_shl[k] : w_rot[k]);
    end

    // Enable chain: a stage may load if it or any later stage holds a bubble,
    // or the consumer takes the output. Written as a running OR from the output
    // backwards, so no signal depends on itself.
    always_comb begin
        logic w_acc;
        w_en  = '0;
        w_acc = out_ready;
        for (int k = AMT_W - 1; k >= 0; k--) begin
            w_acc   = w_acc || !r_v[k];
            w_en[k] = w_acc;
        end
    end

    // Stage update: clear everything on reset, otherwise load when enabled, else hold
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < AMT_W; k++) begin
                r_v[k] <= 1'b0;
                r_d[k] <= '0;
                r_a[k] <= '0;
                r_m[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < AMT_W; k++) begin
                if (w_en[k]) begin
                    r_v[k] <= w_src_v[k];
                    r_d[k] <= w_nxt_d[k];
                    r_a[k] <= w_src_a[k];
                    r_m[k] <= w_src_m[k];
                end
            end
        end
    end

    assign in_ready  = w_en[0];
    assign out_valid = r_v[AMT_W-1];
    assign out_data  = r_d[AMT_W-1];

endmodule

// File: doc/pipelined_left_rotator.md
# pipelined_left_rotator

Parameterized, pipelined left barrel rotator/shifter with valid/ready handshakes on both sides. It is the left-direction counterpart of the team's combinational right rotator, and it scales to any power-of-two width. It uses one register stage per amount bit, so timing closes at wide datapaths. Intended for datapath alignment and packing logic, sitting between a producer and consumer that both use valid/ready flow control.

## Interface
Parameters:
- WIDTH, default 8: data width. Must be a power of two, ≥ 2.
- AMT_W, derived localparam = log2(WIDTH): width of the amount field and number of pipeline stages.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- reset, input, 1: synchronous, active-high.
- in_valid, input, 1: producer presents a request.
- in_ready, output, 1: block accepts the request this cycle.
- in_data, input, WIDTH: operand.
- in_amt, input, AMT_W: left shift/rotate amount, 0..WIDTH-1.
- in_mode, input, 1: 0 = rotate left (MSBs wrap into LSBs); 1 = logical shift left (LSBs zero-filled, MSBs discarded).
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer accepts the result.
- out_data, output, WIDTH: result.

## Operation
- A transfer occurs on either side when valid && ready are both high at a rising edge.
- The pipeline has AMT_W stage registers, S0..S(AMT_W-1). Each holds:
  - v: valid bit
  - d: data, WIDTH bits
  - a: amount, AMT_W bits
  - m: mode, 1 bit
- Stage k applies a displacement of 2^k when amount bit k is set, otherwise passes data through unchanged.
  - S0 applies bit 0 to in_data on load.
  - S(k) applies bit k to S(k-1).d.
  - Rotate mode: d' = {d[WIDTH-1-2^k:0], d[WIDTH-1:WIDTH-2^k]}.
  - Shift mode: d' = {d[WIDTH-1-2^k:0], 2^k zeros}.
- Amount and mode travel with the data. Each stage consumes only its own amount bit.
- S(AMT_W-1) is the output register:
  - out_valid = S(AMT_W-1).v
  - out_data = S(AMT_W-1).d
- Flow control is an elastic pipeline with bubble collapse:
  - en(AMT_W-1) = !v(AMT_W-1) || out_ready
  - en(k) = !v(k) || en(k+1)
  - in_ready = en(0), a combinational chain.
- Stage k loads when en(k) is high:
  - S0 takes v = in_valid.
  - S(k) takes v = S(k-1).v.
  - A stage holds its contents when en(k) is low.
- Amount 0 returns the input unchanged in both modes, after the full latency.
- Ordering is strictly FIFO. No result is dropped or duplicated under backpressure.
- Capacity is AMT_W results in flight. With out_ready low and all stages valid, in_ready is low.

## Timing
- Reset (synchronous):
  - All v = 0 and all d, a, m = 0 on the first edge with reset high.
  - After reset: out_valid = 0, out_data = 0.
  - in_ready = 1 in the cycle reset deasserts, since the pipeline is empty.
- Latency:
  - A request accepted at edge N gives out_valid = 1 after edge N+AMT_W-1 when unstalled. This is 3 cycles of register delay for WIDTH=8 (S0 loads at N, S2 at N+2).
  - Backpressure adds one cycle per stalled cycle.
- Throughput: one result per cycle while out_ready = 1.
- Simultaneous accept and emit in the same cycle with a full pipeline is allowed: in_ready = 1 when out_ready = 1.
- out_data and out_valid must stay stable while out_valid && !out_ready.
- Reset mid-operation discards all in-flight results. No output is produced for them.
- in_amt and in_mode are sampled only on the accepting edge.

## Test plan
- Rotate, WIDTH=8: in_data=8'b1000_0001, in_amt=1, in_mode=0 → out_data=8'b0000_0011, with out_valid rising 3 edges after accept.
- Shift and wrap, WIDTH=8:
  - 8'hFF, amt=3, mode=1 → 8'hF8.
  - 8'h01, amt=7, mode=0 → 8'h80.
  - 8'h80, amt=1, mode=1 → 8'h00.
  - 8'hA5, amt=0 → 8'hA5.
- Backpressure, WIDTH=8: hold out_ready=0 and offer 4 back-to-back requests (8'h01, amt 1..4, rotate).
  - Exactly 3 are accepted, then in_ready=0 and out_data holds 8'h02.
  - Raise out_ready: outputs appear in order 8'h02, 8'h04, 8'h08, then the 4th request (8'h10) is accepted and emitted.
- Streaming: in_valid=1 and out_ready=1 for 256 cycles with random data, amt and mode. Results must match a reference model in order at one per cycle.
- Random out_ready toggling: check stability of out_data while stalled.
- Reset: assert reset for 1 cycle with 2 items in flight → out_valid=0 the following cycle, no stale outputs afterwards, and in_ready=1.
- WIDTH=16 (AMT_W=4): exhaustive amt 0..15 × both modes on 16'h8001. Rotate amt=15 → 16'hC000; shift amt=15 → 16'h8000. Latency is 4 register stages.
